xty_sequencer: RTL and testbench



---
 rtl/xty_sequencer.sv | 129 ++++++++++++
 tb/tb_xty_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xty_sequencer.sv
// xty_sequencer: sequences X/Y memory reads and multiply-accumulates to produce the X^T*Y vector
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start                      begin a run, accepted only in IDLE; n_samples, n_features,
//                              x_base and y_base are latched on that edge
//   x_addr, x_rd, x_data       X read port (row-major N x D, data valid RD_LAT cycles after x_rd)
//   y_addr, y_rd, y_data       Y read port (y_rd always equals x_rd)
//   res_we, res_addr, res_data one write per feature column j carrying the fixed-point result
//   busy, finished             busy from accept through DONE; finished pulses during DONE
// Optional: define XTY_SAT_EN to saturate out-of-range results instead of truncating them.
module xty_sequencer #(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 72,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_samples,
    input  logic [ADDR_W-1:0] n_features,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] y_base,
    output logic [ADDR_W-1:0] x_addr,
    output logic              x_rd,
    input  logic [DATA_W-1:0] x_data,
    output logic [ADDR_W-1:0] y_addr,
    output logic              y_rd,
    input  logic [DATA_W-1:0] y_data,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              finished
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]               state;
    logic [ADDR_W-1:0]        n_r, d_r, xb_r, yb_r, i, j;
    logic [RD_LAT-1:0]        vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DATA_W-1:0] prod;

    assign prod     = $signed(x_data) * $signed(y_data);
    assign x_rd     = state == ISSUE;
    assign y_rd     = x_rd;
    assign res_we   = state == WRITE;
    assign res_addr = j;
    assign busy     = state != IDLE;
    assign finished = state == DONE;

`ifdef XTY_SAT_EN
    // Bits above the result's sign bit must all match it, otherwise the value is out of range.
    logic [ACC_W-FRAC-DATA_W:0] hi;
    assign hi = acc[ACC_W-1:FRAC+DATA_W-1];
    always_comb
        res_data = (&hi || ~|hi) ? acc[FRAC+DATA_W-1:FRAC]
                 : acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign res_data = acc[FRAC+DATA_W-1:FRAC];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            n_r    <= '0;
            d_r    <= '0;
            xb_r   <= '0;
            yb_r   <= '0;
            i      <= '0;
            j      <= '0;
            x_addr <= '0;
            y_addr <= '0;
            vld    <= '0;
            acc    <= '0;
        end else begin
            // vld tags the cycle on which each issued read returns its data
            vld <= (vld << 1) | RD_LAT'(x_rd);
            if (vld[RD_LAT-1])
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            case (state)
                IDLE: if (start) begin
                    n_r   <= n_samples;
                    d_r   <= n_features;
                    xb_r  <= x_base;
                    yb_r  <= y_base;
                    j     <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    i      <= '0;
                    x_addr <= xb_r + j;
                    y_addr <= yb_r;
                    acc    <= '0;
                    state  <= d_r == '0 ? DONE : n_r == '0 ? WRITE : ISSUE;
                end
                ISSUE: begin
                    // stepping by D walks down column j of the row-major X
                    x_addr <= x_addr + d_r;
                    y_addr <= y_addr + ADDR_W'(1);
                    i      <= i + ADDR_W'(1);
                    if (i == n_r - ADDR_W'(1)) begin
                        i     <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    i <= i + ADDR_W'(1);
                    if (i == ADDR_W'(RD_LAT - 1))
                        state <= WRITE;
                end
                WRITE: if (j == d_r - ADDR_W'(1))
                    state <= DONE;
                else begin
                    j     <= j + ADDR_W'(1);
                    state <= LOAD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xty_sequencer.sv
// tb_xty_sequencer: table-driven bench with read/write scoreboards for two xty_sequencer instances (RD_LAT 1 and 3)
module tb_xty_sequencer;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef XTY_SAT_EN
    localparam logic [DW-1:0] BIG_EXP = 32'h7FFFFFFF;
`else
    localparam logic [DW-1:0] BIG_EXP = 32'h00040000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         start = '0;
    logic [AW-1:0]      n_samples = '0, n_features = '0, x_base = '0, y_base = '0;
    logic [1:0][AW-1:0] x_addr, y_addr, res_addr;
    logic [1:0]         x_rd, y_rd, res_we, busy, finished;
    logic [1:0][DW-1:0] x_data, y_data, res_data;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gd
            xty_sequencer #(.RD_LAT(g == 0 ? 1 : 3)) dut (
                .clk(clk), .reset(reset), .start(start[g]),
                .n_samples(n_samples), .n_features(n_features), .x_base(x_base), .y_base(y_base),
                .x_addr(x_addr[g]), .x_rd(x_rd[g]), .x_data(x_data[g]),
                .y_addr(y_addr[g]), .y_rd(y_rd[g]), .y_data(y_data[g]),
                .res_we(res_we[g]), .res_addr(res_addr[g]), .res_data(res_data[g]),
                .busy(busy[g]), .finished(finished[g])
            );
        end
    endgenerate

    logic [DW-1:0] x_mem [1024];
    logic [DW-1:0] y_mem [1024];
    logic [DW-1:0] xp [2][4];
    logic [DW-1:0] yp [2][4];

    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            for (int s = 3; s > 0; s--) begin
                xp[k][s] <= xp[k][s-1];
                yp[k][s] <= yp[k][s-1];
            end
            xp[k][0] <= x_rd[k] ? x_mem[x_addr[k]] : 32'hDEADBEEF;
            yp[k][0] <= y_rd[k] ? y_mem[y_addr[k]] : 32'hDEADBEEF;
        end
    assign x_data[0] = xp[0][0];
    assign y_data[0] = yp[0][0];
    assign x_data[1] = xp[1][2];
    assign y_data[1] = yp[1][2];

    typedef struct {int k; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct {int k; logic [AW-1:0] xa; logic [AW-1:0] ya;} rd_t;
    typedef struct {
        int k; int n; int d; int xb; int yb;
        logic [0:8][DW-1:0] xs;
        logic [0:3][DW-1:0] ys;
        logic [0:2][DW-1:0] ex;
        int fin; int poke; bit hold;
    } vec_t;

    wr_t  wq[$];
    rd_t  rq[$];
    vec_t vt[8];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    wr_t we;
    rd_t re;
    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            if (res_we[k]) begin
                if (wq.size() == 0 || wq[0].k != k) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write dut%0d: addr %0d data %08h, none expected", k, res_addr[k], res_data[k]);
                end else begin
                    we = wq.pop_front();
                    chk("res_addr", 64'(res_addr[k]), 64'(we.a));
                    chk("res_data", 64'(res_data[k]), 64'(we.d));
                end
            end
            if (x_rd[k] || y_rd[k]) begin
                chk("rd_pair", 64'({x_rd[k], y_rd[k]}), 64'(2'b11));
                if (rq.size() == 0 || rq[0].k != k) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read dut%0d: x_addr %0d y_addr %0d, none expected", k, x_addr[k], y_addr[k]);
                end else begin
                    re = rq.pop_front();
                    chk("x_addr", 64'(x_addr[k]), 64'(re.xa));
                    chk("y_addr", 64'(y_addr[k]), 64'(re.ya));
                end
            end
        end

    task automatic fill(input vec_t v);
        for (int t = 0; t < v.n * v.d; t++) x_mem[(v.xb + t) % 1024] = v.xs[t];
        for (int t = 0; t < v.n; t++) y_mem[(v.yb + t) % 1024] = v.ys[t];
    endtask

    task automatic accept(input vec_t v);
        bit idle;
        int guard;
        n_samples  = AW'(v.n);
        n_features = AW'(v.d);
        x_base     = AW'(v.xb);
        y_base     = AW'(v.yb);
        start[v.k] = 1'b1;
        guard = 0;
        do begin
            idle = !busy[v.k];
            @(posedge clk);
            #1;
            guard++;
        end while (!idle && guard < 8);
        start[v.k] = 1'b0;
        n_samples  = AW'($urandom);
        n_features = AW'($urandom);
        x_base     = AW'($urandom);
        y_base     = AW'($urandom);
        chk("busy_after_accept", 64'(busy[v.k]), 64'(1));
    endtask

    task automatic run(input vec_t v);
        int cyc;
        fill(v);
        for (int j = 0; j < v.d; j++)
            for (int i = 0; i < v.n; i++)
                rq.push_back('{k: v.k, xa: AW'(v.xb + i * v.d + j), ya: AW'(v.yb + i)});
        for (int j = 0; j < v.d; j++)
            wq.push_back('{k: v.k, a: AW'(j), d: v.ex[j]});
        accept(v);
        cyc = 1;
        while (!finished[v.k] && cyc < 400) begin
            if (cyc == v.poke) start[v.k] = 1'b1;
            @(posedge clk);
            #1;
            start[v.k] = 1'b0;
            cyc++;
        end
        chk("finish_cycle", 64'(cyc), 64'(v.fin));
        chk("busy_in_done", 64'(busy[v.k]), 64'(1));
        chk("reads_left", 64'(rq.size()), 64'(0));
        chk("writes_left", 64'(wq.size()), 64'(0));
        rq.delete();
        wq.delete();
        if (v.hold)
            start[v.k] = 1'b1;
        else begin
            @(posedge clk);
            #1;
            chk("busy_idle", 64'(busy[v.k]), 64'(0));
            chk("finished_pulse", 64'(finished[v.k]), 64'(0));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = '{k: 0, n: 2, d: 2, xb: 0, yb: 0,
                  xs: {32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 160'h0},
                  ys: {32'h00050000, 32'h00060000, 64'h0},
                  ex: {32'h00170000, 32'h00220000, 32'h0}, fin: 11, poke: 4, hold: 1'b1};
        vt[1] = '{k: 0, n: 1, d: 1, xb: 5, yb: 9,
                  xs: {32'hFFFE0000, 256'h0}, ys: {32'h00030000, 96'h0},
                  ex: {32'hFFFA0000, 64'h0}, fin: 5, poke: 0, hold: 1'b0};
        vt[2] = '{k: 0, n: 0, d: 3, xb: 0, yb: 0, xs: '0, ys: '0,
                  ex: '0, fin: 7, poke: 0, hold: 1'b1};
        vt[3] = '{k: 0, n: 2, d: 0, xb: 0, yb: 0, xs: '0, ys: '0,
                  ex: '0, fin: 2, poke: 0, hold: 1'b0};
        vt[4] = '{k: 0, n: 1, d: 1, xb: 100, yb: 200,
                  xs: {32'hFFFFFFFF, 256'h0}, ys: {32'h00008000, 96'h0},
                  ex: {32'hFFFFFFFF, 64'h0}, fin: 5, poke: 0, hold: 1'b0};
        vt[5] = '{k: 1, n: 2, d: 2, xb: 0, yb: 0,
                  xs: {32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 160'h0},
                  ys: {32'h00050000, 32'h00060000, 64'h0},
                  ex: {32'h00170000, 32'h00220000, 32'h0}, fin: 15, poke: 3, hold: 1'b0};
        vt[6] = '{k: 1, n: 4, d: 1, xb: 300, yb: 400,
                  xs: {{4{32'h7FFF0000}}, 160'h0}, ys: {4{32'h7FFF0000}},
                  ex: {BIG_EXP, 64'h0}, fin: 10, poke: 0, hold: 1'b0};
        vt[7] = '{k: 1, n: 3, d: 3, xb: 1022, yb: 1023,
                  xs: {32'h00010000, 32'h00020000, 32'h00030000,
                       32'hFFFF0000, 32'h00000000, 32'h00020000,
                       32'h00040000, 32'h00010000, 32'hFFFD0000},
                  ys: {32'h00020000, 32'hFFFF0000, 32'h00008000, 32'h0},
                  ex: {32'h00050000, 32'h00048000, 32'h00028000}, fin: 25, poke: 0, hold: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", 64'(busy[k]), 64'(0));
            chk("reset_finished", 64'(finished[k]), 64'(0));
            chk("reset_rd", 64'({x_rd[k], y_rd[k]}), 64'(0));
            chk("reset_we", 64'(res_we[k]), 64'(0));
            chk("reset_x_addr", 64'(x_addr[k]), 64'(0));
            chk("reset_res_data", 64'(res_data[k]), 64'(0));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 8; t++) run(vt[t]);

        fill(vt[5]);
        rq.push_back('{k: 1, xa: AW'(0), ya: AW'(0)});
        rq.push_back('{k: 1, xa: AW'(2), ya: AW'(1)});
        accept(vt[5]);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_busy", 64'(busy[1]), 64'(0));
        chk("midreset_rd", 64'(x_rd[1]), 64'(0));
        chk("midreset_we", 64'(res_we[1]), 64'(0));
        chk("midreset_finished", 64'(finished[1]), 64'(0));
        chk("midreset_x_addr", 64'(x_addr[1]), 64'(0));
        chk("midreset_y_addr", 64'(y_addr[1]), 64'(0));
        chk("midreset_res_data", 64'(res_data[1]), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("midreset_reads_left", 64'(rq.size()), 64'(0));
        chk("midreset_busy_later", 64'(busy[1]), 64'(0));
        rq.delete();
        run(vt[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
